// File: rtl/timing_pkg.sv
// Shared types and helpers for the timing-bus receiver.
package timing_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        ERROR
    } state_t;

    localparam int WIDTH_DEF = 8;

    function automatic int unsigned next_idx(input int unsigned prev, input int unsigned width);
        return (prev + 1) % width;
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder with a legality flag.
module onehot_to_bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         timing_in,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     onehot
);

    localparam int CNT_W = $clog2(WIDTH);

    // OR-ing the positions is only meaningful when onehot is true.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (timing_in[i]) begin
                idx = idx | i[CNT_W-1:0];
            end
        end
    end

    assign onehot = (timing_in != '0) && ((timing_in & (timing_in - WIDTH'(1))) == '0);

endmodule

// File: rtl/timing_onehot_encoder.sv
// Re-encodes the one-hot timing bus to a step number and flags illegal vectors or steps.
// Optional hold-timeout stall detection is built when HOLD_TIMEOUT_EN is defined.
module timing_onehot_encoder
    import timing_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int HOLD_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         timing_in,
    input  logic                     err_clr,
    output logic [$clog2(WIDTH)-1:0] step_out,
    output logic                     step_valid,
    output logic                     wrap_pulse,
    output logic                     clr_pulse,
    output logic                     err_onehot,
    output logic                     err_seq,
    output logic                     stall
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    logic [CNT_W-1:0]   prev_idx;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   nxt_idx;
    logic               onehot;

    onehot_to_bin #(.WIDTH(WIDTH)) u_enc (
        .timing_in (timing_in),
        .idx       (idx),
        .onehot    (onehot)
    );

    assign nxt_idx = CNT_W'(next_idx(32'(prev_idx), WIDTH));

`ifdef HOLD_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              stall_r;

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_W'(HOLD_LIMIT)) ? v : v + 1'b1;
    endfunction

    assign stall = stall_r;
`else
    // Constant zero for any legal HOLD_LIMIT; the comparison only keeps the parameter referenced.
    assign stall = (HOLD_LIMIT < 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            prev_idx   <= '0;
            step_out   <= '0;
            step_valid <= 1'b0;
            wrap_pulse <= 1'b0;
            clr_pulse  <= 1'b0;
            err_onehot <= 1'b0;
            err_seq    <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt   <= '0;
            stall_r    <= 1'b0;
`endif
        end else begin
            wrap_pulse <= 1'b0;
            clr_pulse  <= 1'b0;
            // Clearing first lets a same-cycle error below win over err_clr.
            if (err_clr) begin
                err_onehot <= 1'b0;
                err_seq    <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
                stall_r    <= 1'b0;
`endif
            end
            case (state)
                IDLE: begin
                    if (onehot) begin
                        step_out   <= idx;
                        prev_idx   <= idx;
                        step_valid <= 1'b1;
                        state      <= TRACK;
`ifdef HOLD_TIMEOUT_EN
                        hold_cnt   <= '0;
`endif
                    end
                end
                TRACK: begin
                    if (!onehot) begin
                        err_onehot <= 1'b1;
                        step_valid <= 1'b0;
                        state      <= ERROR;
                    end else if (idx == prev_idx) begin
`ifdef HOLD_TIMEOUT_EN
                        hold_cnt <= sat_inc(hold_cnt);
                        if (int'(hold_cnt) + 1 >= HOLD_LIMIT) begin
                            stall_r <= 1'b1;
                        end
`endif
                    end else if (idx == nxt_idx) begin
                        step_out   <= idx;
                        prev_idx   <= idx;
                        wrap_pulse <= (prev_idx == CNT_W'(WIDTH - 1));
`ifdef HOLD_TIMEOUT_EN
                        hold_cnt   <= '0;
`endif
                    end else if (idx == '0) begin
                        step_out  <= '0;
                        prev_idx  <= '0;
                        clr_pulse <= 1'b1;
`ifdef HOLD_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end else begin
                        err_seq    <= 1'b1;
                        step_valid <= 1'b0;
                        state      <= ERROR;
                    end
                end
                ERROR: begin
                    if (err_clr) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timing_onehot_encoder.sv
// Scoreboard bench for timing_onehot_encoder: directed scenarios followed by random traffic.
module tb_timing_onehot_encoder;

    localparam int W     = 8;
    localparam int CW    = 3;
    localparam int LIMIT = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  timing_in = '0;
    logic          err_clr = 1'b0;
    logic [CW-1:0] step_out;
    logic          step_valid, wrap_pulse, clr_pulse, err_onehot, err_seq, stall;

    always #5 clk = ~clk;

    timing_onehot_encoder #(.WIDTH(W), .HOLD_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .timing_in  (timing_in),
        .err_clr    (err_clr),
        .step_out   (step_out),
        .step_valid (step_valid),
        .wrap_pulse (wrap_pulse),
        .clr_pulse  (clr_pulse),
        .err_onehot (err_onehot),
        .err_seq    (err_seq),
        .stall      (stall)
    );

    typedef struct packed {
        logic [CW-1:0] step;
        logic          valid;
        logic          wrap;
        logic          clrp;
        logic          eo;
        logic          es;
        logic          stall;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: what the receiver should believe after each edge.
    bit m_track, m_err, m_valid, m_wrap, m_clrp, m_eo, m_es, m_stall;
    int m_step, m_holds;

    function automatic logic [W-1:0] oh(input int i);
        logic [W-1:0] one;
        one = W'(1);
        return one << i;
    endfunction

    function automatic int hot_pos(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.step  = CW'(m_step);
        o.valid = m_valid;
        o.wrap  = m_wrap;
        o.clrp  = m_clrp;
        o.eo    = m_eo;
        o.es    = m_es;
        o.stall = m_stall;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.step  = step_out;
        o.valid = step_valid;
        o.wrap  = wrap_pulse;
        o.clrp  = clr_pulse;
        o.eo    = err_onehot;
        o.es    = err_seq;
        o.stall = stall;
        return o;
    endfunction

    task automatic model_reset();
        m_track = 0; m_err = 0; m_valid = 0; m_wrap = 0; m_clrp = 0;
        m_eo = 0; m_es = 0; m_stall = 0; m_step = 0; m_holds = 0;
    endtask

    task automatic model_step(input logic [W-1:0] ti, input logic clr);
        int ones, pos;
        ones = $countones(ti);
        pos  = hot_pos(ti);
        m_wrap = 0;
        m_clrp = 0;
        if (clr) begin
            m_eo = 0; m_es = 0; m_stall = 0;
        end
        if (m_err) begin
            if (clr) m_err = 0;
        end else if (!m_track) begin
            if (ones == 1) begin
                m_step = pos; m_valid = 1; m_track = 1; m_holds = 0;
            end
        end else if (ones != 1) begin
            m_eo = 1; m_valid = 0; m_err = 1; m_track = 0;
        end else if (pos == m_step) begin
            m_holds++;
`ifdef HOLD_TIMEOUT_EN
            if (m_holds >= LIMIT) m_stall = 1;
`endif
        end else if (pos == (m_step + 1) % W) begin
            m_wrap = (m_step == W - 1);
            m_step = pos;
            m_holds = 0;
        end else if (pos == 0) begin
            m_clrp = 1; m_step = 0; m_holds = 0;
        end else begin
            m_es = 1; m_valid = 0; m_err = 1; m_track = 0;
        end
    endtask

    task automatic drive(input logic [W-1:0] ti, input logic clr, input logic rn);
        @(negedge clk);
        timing_in = ti;
        err_clr   = clr;
        reset     = rn;
        if (!rn) model_reset();
        else model_step(ti, clr);
        exp_q.push_back(model_obs());
    endtask

    // Monitor: one output word per clock, compared against the oldest prediction.
    always @(posedge clk) begin
        obs_t e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_obs();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_out t=%0t got step=%0d v=%b w=%b c=%b eo=%b es=%b st=%b required step=%0d v=%b w=%b c=%b eo=%b es=%b st=%b",
                         $time, a.step, a.valid, a.wrap, a.clrp, a.eo, a.es, a.stall,
                         e.step, e.valid, e.wrap, e.clrp, e.eo, e.es, e.stall);
            end
        end
    end

    initial begin
        logic [W-1:0] ti;
        logic         clr;
        int           r;
        model_reset();

        // Reset held, then a full walk with wrap.
        drive('0, 1'b0, 1'b0);
        drive(oh(3), 1'b0, 1'b0);
        for (int i = 0; i < W; i++) drive(oh(i), 1'b0, 1'b1);
        drive(oh(0), 1'b0, 1'b1);

        // Early clear back to T0.
        for (int i = 1; i < 4; i++) drive(oh(i), 1'b0, 1'b1);
        drive(oh(0), 1'b0, 1'b1);
        drive(oh(0), 1'b0, 1'b1);

        // Empty vector at T2, recovery through err_clr, restart at T5.
        drive(oh(1), 1'b0, 1'b1);
        drive(oh(2), 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1);
        drive(8'b1010_0000, 1'b0, 1'b1);
        drive(oh(6), 1'b1, 1'b1);
        drive(8'b0000_0011, 1'b0, 1'b1);
        drive(oh(5), 1'b0, 1'b1);

        // Illegal jump with simultaneous err_clr: error still latched.
        drive(oh(6), 1'b0, 1'b1);
        drive(oh(7), 1'b0, 1'b1);
        drive(oh(0), 1'b0, 1'b1);
        drive(oh(1), 1'b0, 1'b1);
        drive(oh(4), 1'b1, 1'b1);
        drive(oh(4), 1'b0, 1'b1);
        drive(oh(2), 1'b1, 1'b1);

        // Long hold at T3 (stall only in the timeout build); then err_clr while tracking.
        drive(oh(3), 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) drive(oh(3), 1'b0, 1'b1);
        drive(oh(3), 1'b1, 1'b1);
        drive(oh(4), 1'b0, 1'b1);
        drive(oh(5), 1'b0, 1'b1);
        drive(oh(6), 1'b0, 1'b1);

        // Asynchronous reset in the middle of a clock period.
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (dut_obs() !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL async_reset got %b required all zero", dut_obs());
        end
        drive(oh(6), 1'b0, 1'b0);
        drive(oh(7), 1'b0, 1'b1);
        drive(oh(0), 1'b0, 1'b1);

        // Random traffic biased toward legal sequences.
        for (int n = 0; n < 800; n++) begin
            r   = int'($urandom_range(0, 99));
            clr = ($urandom_range(0, 15) == 0);
            if (m_err) begin
                ti  = W'($urandom);
                clr = ($urandom_range(0, 2) == 0);
            end else if (!m_track) begin
                ti = (r < 80) ? oh(int'($urandom_range(0, W - 1))) : W'($urandom);
            end else if (r < 30) ti = oh(m_step);
            else if (r < 65) ti = oh((m_step + 1) % W);
            else if (r < 75) ti = oh(0);
            else if (r < 85) ti = oh(int'($urandom_range(0, W - 1)));
            else if (r < 92) ti = '0;
            else ti = W'($urandom);
            drive(ti, clr, ($urandom_range(0, 299) != 0));
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
